cyphertext_mem_ctrl: RTL

Controller that shares the single-port cyphertext RAM between the AES core's result stream (writer) and a host readback port (reader). It assigns sequential write addresses to finished blocks, arbitrates each cycle between a pending write and a pending read, and tracks fill level, full and overflow status. It sits between the AES round datapath's finish/cyphertext outputs and the cyphertext RAM.

---
 rtl/cyphertext_mem_ctrl_pkg.sv | 18 +
 rtl/rr_arb2.sv | 39 +++
 rtl/cyphertext_mem_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cyphertext_mem_ctrl_pkg.sv
// Shared definitions for the cyphertext memory controller.
//   DEF_TEXT_WIDTH  - default cyphertext block width in bits
//   DEF_ADDR_WIDTH  - default RAM address width
//   DEF_MEMORY_SIZE - default number of RAM entries (<= 2**ADDR_WIDTH)
//   ctrl_state_e    - controller FSM states (IDLE=0, RUN=1, FULL=2)
package cyphertext_mem_ctrl_pkg;

    localparam int unsigned DEF_TEXT_WIDTH  = 128;
    localparam int unsigned DEF_ADDR_WIDTH  = 8;
    localparam int unsigned DEF_MEMORY_SIZE = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant flag.
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   req_i  - request vector, bit 0 / bit 1
//   gnt_o  - one-hot grant (combinational), zero when nothing is requested
// A lone requester always wins. With both requesting, the winner is the
// requester that was not granted last; the flag follows every grant.
module rr_arb2 #(
    parameter bit RESET_LAST = 1'b1   // requester treated as "granted last" out of reset
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;   // 1: requester 1 was granted last

    always_comb begin
        gnt_o = '0;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= RESET_LAST;
        end else if (gnt_o[0]) begin
            last_q <= 1'b0;
        end else if (gnt_o[1]) begin
            last_q <= 1'b1;
        end
    end

endmodule

// File: rtl/cyphertext_mem_ctrl.sv
// Cyphertext RAM controller: shares one single-port RAM between the AES
// core's finished-block stream (writer) and a host readback port (reader).
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   start_i               - begin a new message: clear count/full/overflow
//   blk_valid_i/_data_i   - finished block from the core, held until accepted
//   blk_ready_o           - block written this cycle
//   rd_req_i/rd_addr_i    - host read request, held until rd_gnt_o
//   rd_gnt_o              - read granted this cycle
//   rd_valid_o/_data_o    - read result, two cycles after the grant
//   rd_err_o              - read address was beyond the written blocks
//   mem_we_o/_addr_o/_wdata_o, mem_rdata_i - RAM interface (registered read)
//   count_o, full_o, ovf_o, busy_o - fill level and status
module cyphertext_mem_ctrl
    import cyphertext_mem_ctrl_pkg::*;
#(
    parameter int unsigned TEXT_WIDTH  = DEF_TEXT_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned MEMORY_SIZE = DEF_MEMORY_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  blk_valid_i,
    input  logic [TEXT_WIDTH-1:0] blk_data_i,
    output logic                  blk_ready_o,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_gnt_o,
    output logic                  rd_valid_o,
    output logic [TEXT_WIDTH-1:0] rd_data_o,
    output logic                  rd_err_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [TEXT_WIDTH-1:0] mem_wdata_o,
    input  logic [TEXT_WIDTH-1:0] mem_rdata_i,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  ovf_o,
    output logic                  busy_o
);

    localparam logic [ADDR_WIDTH:0] MEM_SIZE_C = (ADDR_WIDTH+1)'(MEMORY_SIZE);
    localparam logic [ADDR_WIDTH:0] COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    ctrl_state_e state_q, state_d;

    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_inc;
    logic                  ovf_q;
    logic [ADDR_WIDTH-1:0] addr_hold_q;

    logic                  wr_req;
    logic [1:0]            arb_req;
    logic [1:0]            arb_gnt;
    logic                  wr_gnt;
    logic                  rd_gnt;
    logic                  rd_addr_bad;

    // Read pipeline: stage 1 waits for the RAM, stage 2 is the output register.
    logic                  p1_valid_q;
    logic                  p1_err_q;
    logic                  rd_valid_q;
    logic                  rd_err_q;
    logic [TEXT_WIDTH-1:0] rd_data_q;

    // Writes compete only in RUN and never in a start cycle; reads always compete.
    assign wr_req    = blk_valid_i && (state_q == RUN) && !start_i;
    assign arb_req   = {rd_req_i, wr_req};
    assign wr_gnt    = arb_gnt[0];
    assign rd_gnt    = arb_gnt[1];
    assign count_inc = count_q + COUNT_ONE;

    assign rd_addr_bad = ({1'b0, rd_addr_i} >= count_q);

    rr_arb2 #(
        .RESET_LAST (1'b1)
    ) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (arb_req),
        .gnt_o (arb_gnt)
    );

    // Next state and RAM-side outputs.
    always_comb begin
        state_d     = state_q;
        blk_ready_o = 1'b0;
        rd_gnt_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = addr_hold_q;
        mem_wdata_o = '0;

        if (start_i) begin
            state_d = RUN;
        end else if ((state_q == RUN) && wr_gnt && (count_inc == MEM_SIZE_C)) begin
            state_d = FULL;
        end

        if (wr_gnt) begin
            blk_ready_o = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = count_q[ADDR_WIDTH-1:0];
            mem_wdata_o = blk_data_i;
        end else if (rd_gnt) begin
            rd_gnt_o    = 1'b1;
            mem_addr_o  = rd_addr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_i) begin
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (wr_gnt) begin
                    count_q <= count_inc;
                end
                if ((state_q == FULL) && blk_valid_i) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    // The RAM address bus keeps its last driven value on idle cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_hold_q <= '0;
        end else if (wr_gnt || rd_gnt) begin
            addr_hold_q <= mem_addr_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p1_valid_q <= 1'b0;
            p1_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            p1_valid_q <= rd_gnt;
            p1_err_q   <= rd_gnt && rd_addr_bad;
            rd_valid_q <= p1_valid_q;
            rd_err_q   <= p1_valid_q && p1_err_q;
            if (p1_valid_q) begin
                rd_data_q <= p1_err_q ? '0 : mem_rdata_i;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign rd_data_o  = rd_data_q;
    assign count_o    = count_q;
    assign full_o     = (count_q == MEM_SIZE_C);
    assign ovf_o      = ovf_q;
    assign busy_o     = (state_q != IDLE);

endmodule
